// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions: control codes, preamble bytes, deframer states and
// small lane/byte helpers.
package xgmii_pkg;

  localparam logic [7:0] XgmiiIdle  = 8'h07;
  localparam logic [7:0] XgmiiStart = 8'hFB;
  localparam logic [7:0] XgmiiTerm  = 8'hFD;
  localparam logic [7:0] XgmiiError = 8'hFE;
  localparam logic [7:0] XgmiiPre   = 8'h55;
  localparam logic [7:0] XgmiiSfd   = 8'hD5;

  typedef enum logic [2:0] {
    StIdle,
    StShiftChk,
    StAligned,
    StShifted,
    StFlush
  } rx_state_e;

  // Contiguous keep for n bytes starting at lane 0 (n = 0..8).
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i] = (4'(i) < n);
    end
    return m;
  endfunction

  function automatic logic [63:0] byte_mask(input logic [7:0] keep);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = {8{keep[i]}};
    end
    return m;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/xgmii_rx_deframer_if.sv
// AXI-Stream style output bundle of the deframer (no tready: XGMII cannot stall).
interface xgmii_rx_deframer_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser);
  modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/xgmii_lane_scan.sv
// Per-word lane classifier: lowest control lane, its code, and an all-data flag.
module xgmii_lane_scan
  import xgmii_pkg::*;
(
  input  logic [63:0] rxd,
  input  logic [7:0]  rxc,
  output logic [2:0]  ctrl_idx,
  output logic [7:0]  ctrl_code,
  output logic        all_data
);

  always_comb begin
    ctrl_idx  = 3'd0;
    ctrl_code = XgmiiIdle;
    all_data  = (rxc == 8'h00);
    // Scan high to low so the lowest control lane wins.
    for (int i = 7; i >= 0; i--) begin
      if (rxc[i]) begin
        ctrl_idx  = 3'(i);
        ctrl_code = rxd[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// XGMII receive deframer: start detection in lane 0/4, preamble strip, lane
// realignment, terminate/error handling, length check and frame counters.
module xgmii_rx_deframer
  import xgmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                xgmii_rxd,
  input  logic [7:0]                 xgmii_rxc,
  xgmii_rx_deframer_if.master        m_axis,
  output logic [31:0]                rx_frames,
  output logic [31:0]                rx_errors
);

  localparam logic [63:0] StartAlignedWord = {XgmiiSfd, {6{XgmiiPre}}, XgmiiStart};
  localparam logic [63:0] StartShiftedWord = {{3{XgmiiPre}}, XgmiiStart, {4{XgmiiIdle}}};
  localparam logic [31:0] ShiftTailWord    = {XgmiiSfd, {3{XgmiiPre}}};

  rx_state_e   state_q, state_d;
  logic [31:0] carry_q;
  logic [2:0]  rem_q, rem_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        hold_valid_q, hold_valid_d;
  logic [63:0] hold_data_q, hold_data_d;
  logic [7:0]  hold_keep_q, hold_keep_d;
  logic        hold_last_q, hold_last_d;
  logic        hold_user_q, hold_user_d;

  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0]  out_keep_q, out_keep_d;
  logic        out_last_q, out_last_d;
  logic        out_user_q, out_user_d;

  logic [31:0] frames_q, frames_d;
  logic [31:0] errors_q, errors_d;

  logic [2:0]  scan_idx;
  logic [7:0]  scan_code;
  logic        scan_all_data;

  logic        start_aligned, start_shifted, shift_ok;
  logic [63:0] asm_word;
  logic [3:0]  frag_n;
  logic [15:0] total;
  logic        err_now;
  logic        emit, emit_last, emit_user;
  logic        load, load_last, load_user;
  logic [63:0] load_data;
  logic [7:0]  load_keep;

  xgmii_lane_scan u_lane_scan (
    .rxd       (xgmii_rxd),
    .rxc       (xgmii_rxc),
    .ctrl_idx  (scan_idx),
    .ctrl_code (scan_code),
    .all_data  (scan_all_data)
  );

  function automatic logic len_bad(input logic [15:0] n);
    return ({16'd0, n} < MIN_LEN) || ({16'd0, n} > MAX_LEN);
  endfunction

  assign start_aligned = (xgmii_rxc == 8'h01) && (xgmii_rxd == StartAlignedWord);
  assign start_shifted = (xgmii_rxc == 8'h1F) && (xgmii_rxd == StartShiftedWord);
  assign shift_ok      = (xgmii_rxc == 8'h00) && (xgmii_rxd[31:0] == ShiftTailWord);

  // Shifted frames take the upper half of the previous word as the low 4 bytes.
  assign asm_word = (state_q == StShifted) ? {xgmii_rxd[31:0], carry_q} : xgmii_rxd;
  assign frag_n   = {1'b0, scan_idx} + ((state_q == StShifted) ? 4'd4 : 4'd0);
  assign total    = sat_add(cnt_q, frag_n);
  assign err_now  = (scan_code != XgmiiTerm);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rem_d        = rem_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_keep_d  = hold_keep_q;
    hold_last_d  = hold_last_q;
    hold_user_d  = hold_user_q;
    out_valid_d  = 1'b0;
    out_data_d   = '0;
    out_keep_d   = '0;
    out_last_d   = 1'b0;
    out_user_d   = 1'b0;
    frames_d     = frames_q;
    errors_d     = errors_q;
    // A finished frame's final word drains regardless of what arrives now.
    emit         = hold_valid_q & hold_last_q;
    emit_last    = hold_last_q;
    emit_user    = hold_user_q;
    load         = 1'b0;
    load_data    = '0;
    load_keep    = '0;
    load_last    = 1'b0;
    load_user    = 1'b0;

    unique case (state_q)
      StIdle, StFlush: begin
        if (state_q == StFlush) begin
          emit      = hold_valid_q;
          load      = 1'b1;
          load_keep = keep_mask({1'b0, rem_q});
          load_data = {32'd0, carry_q} & byte_mask(load_keep);
          load_last = 1'b1;
          load_user = err_q | len_bad(sat_add(cnt_q, {1'b0, rem_q}));
          state_d   = StIdle;
        end
        if (start_aligned) begin
          state_d = StAligned;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (start_shifted) begin
          state_d = StShiftChk;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end

      StShiftChk: begin
        state_d = shift_ok ? StShifted : StIdle;
      end

      StAligned, StShifted: begin
        emit = hold_valid_q;
        if (scan_all_data) begin
          load      = 1'b1;
          load_data = asm_word;
          load_keep = 8'hFF;
          cnt_d     = sat_add(cnt_q, 4'd8);
        end else if (frag_n == 4'd0) begin
          // Nothing follows the held word; empty frames produce no output.
          if (!hold_last_q) begin
            emit_last = 1'b1;
            emit_user = err_now | len_bad(cnt_q);
          end
          state_d = StIdle;
        end else if (frag_n <= 4'd8) begin
          load      = 1'b1;
          load_keep = keep_mask(frag_n);
          load_data = asm_word & byte_mask(load_keep);
          load_last = 1'b1;
          load_user = err_now | len_bad(total);
          state_d   = StIdle;
        end else begin
          // Carry plus terminator fragment overflows one word: split it.
          load      = 1'b1;
          load_data = asm_word;
          load_keep = 8'hFF;
          cnt_d     = sat_add(cnt_q, 4'd8);
          rem_d     = 3'(frag_n - 4'd8);
          err_d     = err_now;
          state_d   = StFlush;
        end
      end

      default: state_d = StIdle;
    endcase

    if (emit) begin
      out_valid_d  = 1'b1;
      out_data_d   = hold_data_q;
      out_keep_d   = hold_keep_q;
      out_last_d   = emit_last;
      out_user_d   = emit_last & emit_user;
      hold_valid_d = 1'b0;
      if (emit_last) begin
        frames_d = frames_q + 32'd1;
        if (emit_user) begin
          errors_d = errors_q + 32'd1;
        end
      end
    end

    if (load) begin
      hold_valid_d = 1'b1;
      hold_data_d  = load_data;
      hold_keep_d  = load_keep;
      hold_last_d  = load_last;
      hold_user_d  = load_user;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      carry_q      <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_user_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= 1'b0;
      frames_q     <= '0;
      errors_q     <= '0;
    end else begin
      state_q      <= state_d;
      carry_q      <= xgmii_rxd[63:32];
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_keep_q  <= hold_keep_d;
      hold_last_q  <= hold_last_d;
      hold_user_q  <= hold_user_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
      out_user_q   <= out_user_d;
      frames_q     <= frames_d;
      errors_q     <= errors_d;
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tkeep  = out_keep_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tuser  = out_user_q;
  assign rx_frames     = frames_q;
  assign rx_errors     = errors_q;

endmodule
